// File: rtl/ad9915_spi_responder.sv
// ---------------------------------------------------------------------------
// ad9915_spi_responder
//
// Device-side emulation of the AD9915 DDS serial register interface. A
// controller drives SClk / nCS / SDIO (plus SyncIO and IO_Update); this block
// decodes write frames into a shadow register bank, copies shadow to active
// on IO_Update, and answers read frames by driving SDIO back.
//
// Ports
//   ipClk, ipReset          system clock (oversamples the bus), async reset
//   ipSClk, ipnCS, ipSDIO   serial bus from the controller
//   opSDIO, opSDIO_En       read data and its output enable
//   ipSyncIO                serial-port reset (aborts frame, not counted)
//   ipIO_Update             rising edge: active bank <= shadow bank
//   ipRdAddr / opRdData     local read port into the active bank (1 cycle)
//   opWrValid/Addr/Data     one pulse per completed in-range write word
//   opUpdatePulse           one pulse when the active bank loads
//   opAbortCount            saturating count of nCS-aborted frames
// ---------------------------------------------------------------------------
module ad9915_spi_responder #(
    parameter int  NUM_REGS    = 16,
    parameter int  SYNC_STAGES = 2,
    localparam int AW          = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic          ipClk,
    input  logic          ipReset,
    input  logic          ipSClk,
    input  logic          ipnCS,
    input  logic          ipSDIO,
    output logic          opSDIO,
    output logic          opSDIO_En,
    input  logic          ipSyncIO,
    input  logic          ipIO_Update,
    input  logic [AW-1:0] ipRdAddr,
    output logic [31:0]   opRdData,
    output logic          opWrValid,
    output logic [6:0]    opWrAddr,
    output logic [31:0]   opWrData,
    output logic          opUpdatePulse,
    output logic [7:0]    opAbortCount
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_INSTR = 3'd1;
    localparam logic [2:0] ST_WDATA = 3'd2;
    localparam logic [2:0] ST_RDATA = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Synchroniser bit order: {IO_Update, SyncIO, SDIO, nCS, SClk}.
    // nCS resets high so leaving reset never looks like a frame start.
    localparam logic [4:0] SYNC_RST   = 5'b00010;
    localparam logic [7:0] NUM_REGS_L = 8'(NUM_REGS);

    logic [SYNC_STAGES-1:0][4:0] sync_q;
    logic [4:0]                  in_s;
    logic [2:0]                  prev_q;   // {IO_Update, nCS, SClk}

    always_ff @(posedge ipClk or posedge ipReset) begin
        if (ipReset) begin
            sync_q <= {SYNC_STAGES{SYNC_RST}};
            prev_q <= 3'b010;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], {ipIO_Update, ipSyncIO, ipSDIO, ipnCS, ipSClk}};
            prev_q <= {in_s[4], in_s[1], in_s[0]};
        end
    end

    assign in_s = sync_q[SYNC_STAGES-1];

    logic sclk_rise, sclk_fall, ncs_fall, ncs_rise, upd_rise, sdio_s, sync_s;
    assign sclk_rise = in_s[0] & ~prev_q[0];
    assign sclk_fall = ~in_s[0] & prev_q[0];
    assign ncs_rise  = in_s[1] & ~prev_q[1];
    assign ncs_fall  = ~in_s[1] & prev_q[1];
    assign sdio_s    = in_s[2];
    assign sync_s    = in_s[3];
    assign upd_rise  = in_s[4] & ~prev_q[2];

    // Frame state
    logic [2:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [6:0]  instr_q, instr_d;     // shifting instruction, then address
    logic [31:0] shift_q, shift_d;
    logic        sdio_q, sdio_d, en_q, en_d;
    logic        wr_valid_q, wr_valid_d, upd_q;
    logic [6:0]  wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d, rd_data_q;
    logic [7:0]  abort_q, abort_d;

    // Register bank
    logic [31:0] active_w [NUM_REGS];
    logic        wr_en;
    logic [31:0] wr_word;

    assign wr_word = {shift_q[30:0], sdio_s};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [31:0] shadow_q, active_q, shadow_nx;
            // Active loads from the post-write shadow so a write finishing
            // in the IO_Update cycle is included in the copy.
            assign shadow_nx = (wr_en && instr_q[AW-1:0] == AW'(gi)) ? wr_word : shadow_q;
            always_ff @(posedge ipClk or posedge ipReset) begin
                if (ipReset) begin
                    shadow_q <= '0;
                    active_q <= '0;
                end else begin
                    shadow_q <= shadow_nx;
                    if (upd_rise) active_q <= shadow_nx;
                end
            end
            assign active_w[gi] = active_q;
        end
    endgenerate

    // At the 8th instruction edge the address is the 6 stored bits + live bit.
    logic [6:0]  addr_nx;
    logic [31:0] rd_word;
    logic        wr_in_range;
    assign addr_nx     = {instr_q[5:0], sdio_s};
    assign rd_word     = ({1'b0, addr_nx} < NUM_REGS_L) ? active_w[addr_nx[AW-1:0]] : 32'd0;
    assign wr_in_range = ({1'b0, instr_q} < NUM_REGS_L);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        instr_d    = instr_q;
        shift_d    = shift_q;
        sdio_d     = sdio_q;
        en_d       = en_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        abort_d    = abort_q;
        wr_en      = 1'b0;
        if (sync_s) begin
            state_d = ST_IDLE;
            en_d    = 1'b0;
            sdio_d  = 1'b0;
            cnt_d   = '0;
        end else if (ncs_rise && (state_q == ST_INSTR || state_q == ST_WDATA || state_q == ST_RDATA)) begin
            state_d = ST_IDLE;
            en_d    = 1'b0;
            sdio_d  = 1'b0;
            cnt_d   = '0;
            if (abort_q != 8'hFF) abort_d = abort_q + 8'd1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ncs_fall) begin
                        state_d = ST_INSTR;
                        cnt_d   = '0;
                    end
                end
                ST_INSTR: begin
                    if (sclk_rise) begin
                        instr_d = {instr_q[5:0], sdio_s};
                        cnt_d   = cnt_q + 5'd1;
                        if (cnt_q == 5'd7) begin
                            cnt_d = '0;
                            if (instr_q[6]) begin
                                state_d = ST_RDATA;
                                shift_d = rd_word;
                                sdio_d  = rd_word[31];
                                en_d    = 1'b1;
                            end else begin
                                state_d = ST_WDATA;
                            end
                        end
                    end
                end
                ST_WDATA: begin
                    if (sclk_rise) begin
                        shift_d = wr_word;
                        cnt_d   = cnt_q + 5'd1;
                        if (cnt_q == 5'd31) begin
                            state_d = ST_DONE;
                            if (wr_in_range) begin
                                wr_en      = 1'b1;
                                wr_valid_d = 1'b1;
                                wr_addr_d  = instr_q;
                                wr_data_d  = wr_word;
                            end
                        end
                    end
                end
                ST_RDATA: begin
                    if (sclk_rise) begin
                        cnt_d = cnt_q + 5'd1;
                        if (cnt_q == 5'd31) begin
                            state_d = ST_DONE;
                            en_d    = 1'b0;
                            sdio_d  = 1'b0;
                        end
                    end else if (sclk_fall && cnt_q != 5'd0) begin
                        // Bit 31 is already on the line from entry; only falls
                        // after a data rising edge advance to the next bit.
                        shift_d = {shift_q[30:0], 1'b0};
                        sdio_d  = shift_q[30];
                    end
                end
                ST_DONE: begin
                    if (ncs_rise) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge ipClk or posedge ipReset) begin
        if (ipReset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            instr_q    <= '0;
            shift_q    <= '0;
            sdio_q     <= 1'b0;
            en_q       <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            abort_q    <= '0;
            upd_q      <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            instr_q    <= instr_d;
            shift_q    <= shift_d;
            sdio_q     <= sdio_d;
            en_q       <= en_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            abort_q    <= abort_d;
            upd_q      <= upd_rise;
            rd_data_q  <= (8'(ipRdAddr) < NUM_REGS_L) ? active_w[ipRdAddr] : 32'd0;
        end
    end

    assign opSDIO        = sdio_q;
    assign opSDIO_En     = en_q;
    assign opRdData      = rd_data_q;
    assign opWrValid     = wr_valid_q;
    assign opWrAddr      = wr_addr_q;
    assign opWrData      = wr_data_q;
    assign opUpdatePulse = upd_q;
    assign opAbortCount  = abort_q;

endmodule

// File: tb/tb_ad9915_spi_responder.sv
// ---------------------------------------------------------------------------
// tb_ad9915_spi_responder
//
// Drives serial frames into ad9915_spi_responder and compares its behaviour
// with a register-bank model (shadow/active arrays, abort counter).
// ---------------------------------------------------------------------------
module tb_ad9915_spi_responder;

    localparam int NR = 16;
    localparam int P  = 5;      // SClk half period in ipClk cycles

    logic        ipClk = 1'b0;
    logic        ipReset, ipSClk, ipnCS, ipSDIO, ipSyncIO, ipIO_Update;
    logic [3:0]  ipRdAddr;
    logic        opSDIO, opSDIO_En, opWrValid, opUpdatePulse;
    logic [6:0]  opWrAddr;
    logic [31:0] opWrData, opRdData;
    logic [7:0]  opAbortCount;

    ad9915_spi_responder #(.NUM_REGS(NR), .SYNC_STAGES(2)) dut (
        .ipClk(ipClk), .ipReset(ipReset), .ipSClk(ipSClk), .ipnCS(ipnCS),
        .ipSDIO(ipSDIO), .opSDIO(opSDIO), .opSDIO_En(opSDIO_En),
        .ipSyncIO(ipSyncIO), .ipIO_Update(ipIO_Update), .ipRdAddr(ipRdAddr),
        .opRdData(opRdData), .opWrValid(opWrValid), .opWrAddr(opWrAddr),
        .opWrData(opWrData), .opUpdatePulse(opUpdatePulse), .opAbortCount(opAbortCount)
    );

    always #5 ipClk = ~ipClk;

    int checks = 0;
    int errors = 0;

    // Reference model
    logic [31:0] m_shadow [NR];
    logic [31:0] m_active [NR];
    int          m_abort;

    // Observed write pulses and update pulses
    logic [38:0] wr_q[$];
    int          upd_cnt = 0;

    always @(negedge ipClk) begin
        if (!ipReset) begin
            if (opWrValid) wr_q.push_back({opWrAddr, opWrData});
            if (opUpdatePulse) upd_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge ipClk);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_shadow[i] = '0;
            m_active[i] = '0;
        end
        m_abort = 0;
    endtask

    // Model effect of a complete frame: only in-range writes land.
    task automatic model_write(input logic [6:0] addr, input logic [31:0] data);
        if (addr < NR) m_shadow[addr] = data;
    endtask

    function automatic logic [31:0] model_read(input logic [6:0] addr);
        return (addr < NR) ? m_active[addr] : 32'd0;
    endfunction

    // Sends nbits of {instr,data}; read bits are sampled just before each
    // SClk rising edge. Optional SyncIO pulse after bit sync_at.
    task automatic do_frame(input logic [7:0] instr, input logic [31:0] data, input int nbits,
                            input int sync_at, input bit keep_cs,
                            output logic [31:0] rd, output logic [39:0] en_seen);
        logic [39:0] tx;
        tx      = {instr, data};
        rd      = '0;
        en_seen = '0;
        @(negedge ipClk);
        ipnCS = 1'b0;
        tick(P);
        for (int i = 0; i < nbits; i++) begin
            ipSDIO = tx[39-i];
            tick(P);
            en_seen[39-i] = opSDIO_En;
            if (i >= 8) rd[39-i] = opSDIO;
            ipSClk = 1'b1;
            tick(P);
            ipSClk = 1'b0;
            if (i + 1 == sync_at) begin
                ipSyncIO = 1'b1;
                tick(4);
                ipSyncIO = 1'b0;
                tick(2);
            end
        end
        if (!keep_cs) begin
            tick(P);
            ipnCS = 1'b1;
            tick(P + 4);
        end
    endtask

    task automatic io_update();
        @(negedge ipClk);
        ipIO_Update = 1'b1;
        tick(4);
        ipIO_Update = 1'b0;
        tick(4);
        for (int i = 0; i < NR; i++) m_active[i] = m_shadow[i];
    endtask

    task automatic test_reset();
        ipReset = 1'b1; ipSClk = 1'b0; ipnCS = 1'b1; ipSDIO = 1'b0;
        ipSyncIO = 1'b0; ipIO_Update = 1'b0; ipRdAddr = '0;
        tick(3);
        ipReset = 1'b0;
        model_reset();
        tick(3);
        checks++;
        if ({opSDIO, opSDIO_En, opWrValid, opUpdatePulse} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 0000", {opSDIO, opSDIO_En, opWrValid, opUpdatePulse});
        end
        checks++;
        if ({opWrAddr, opWrData, opRdData, opAbortCount} !== '0) begin
            errors++;
            $display("FAIL reset_bus: addr %h wdata %h rdata %h abort %0d required all 0",
                     opWrAddr, opWrData, opRdData, opAbortCount);
        end
        $display("reset: outputs checked");
    endtask

    task automatic test_write_update();
        logic [31:0] rd;
        logic [39:0] en;
        int          u0;
        do_frame(8'h05, 32'h12345678, 40, -1, 0, rd, en);
        model_write(7'h05, 32'h12345678);
        checks++;
        if (wr_q.size() !== 1) begin
            errors++;
            $display("FAIL wr_pulse_count: got %0d required 1", wr_q.size());
        end else begin
            checks++;
            if (wr_q[0] !== {7'h05, 32'h12345678}) begin
                errors++;
                $display("FAIL wr_word: got %h required %h", wr_q[0], {7'h05, 32'h12345678});
            end
        end
        wr_q.delete();
        checks++;
        if (en !== 40'd0) begin
            errors++;
            $display("FAIL wr_sdio_en: got %h required 0", en);
        end
        u0 = upd_cnt;
        io_update();
        checks++;
        if (upd_cnt !== u0 + 1) begin
            errors++;
            $display("FAIL update_pulse: got %0d pulses required 1", upd_cnt - u0);
        end
        ipRdAddr = 4'd5;
        tick(2);
        checks++;
        if (opRdData !== m_active[5]) begin
            errors++;
            $display("FAIL rdport_5: got %h required %h", opRdData, m_active[5]);
        end
        $display("write 0x05 = 12345678, update, local read %h", opRdData);
    endtask

    task automatic test_read_shadow();
        logic [31:0] rd;
        logic [39:0] en;
        do_frame(8'h03, 32'hDEADBEEF, 40, -1, 0, rd, en);
        model_write(7'h03, 32'hDEADBEEF);
        wr_q.delete();
        do_frame(8'h83, 32'h0, 40, -1, 0, rd, en);
        checks++;
        if (rd !== model_read(7'h03)) begin
            errors++;
            $display("FAIL read_before_update: got %h required %h", rd, model_read(7'h03));
        end
        checks++;
        if (en !== {8'h00, 32'hFFFFFFFF}) begin
            errors++;
            $display("FAIL read_sdio_en: got %h required %h", en, {8'h00, 32'hFFFFFFFF});
        end
        checks++;
        if (opSDIO_En !== 1'b0) begin
            errors++;
            $display("FAIL read_en_after: got %b required 0", opSDIO_En);
        end
        io_update();
        do_frame(8'h83, 32'h0, 40, -1, 0, rd, en);
        checks++;
        if (rd !== model_read(7'h03)) begin
            errors++;
            $display("FAIL read_after_update: got %h required %h", rd, model_read(7'h03));
        end
        $display("read 0x03 after update = %h", rd);
    endtask

    task automatic test_syncio();
        logic [31:0] rd;
        logic [39:0] en;
        do_frame(8'h81, 32'h0, 3, 3, 0, rd, en);
        do_frame(8'h01, 32'h0000FFFF, 40, -1, 0, rd, en);
        model_write(7'h01, 32'h0000FFFF);
        checks++;
        if (wr_q.size() !== 1) begin
            errors++;
            $display("FAIL syncio_wr_count: got %0d required 1", wr_q.size());
        end else begin
            checks++;
            if (wr_q[0] !== {7'h01, 32'h0000FFFF}) begin
                errors++;
                $display("FAIL syncio_wr_word: got %h required %h", wr_q[0], {7'h01, 32'h0000FFFF});
            end
        end
        wr_q.delete();
        checks++;
        if (opAbortCount !== 8'(m_abort)) begin
            errors++;
            $display("FAIL syncio_abort: got %0d required %0d", opAbortCount, m_abort);
        end
        $display("syncio mid-instruction, then write 0x01 = 0000FFFF");
    endtask

    task automatic test_bad_addr();
        logic [31:0] rd;
        logic [39:0] en;
        do_frame(8'h00, 32'hCAFEF00D, 40, -1, 0, rd, en);
        model_write(7'h00, 32'hCAFEF00D);
        wr_q.delete();
        do_frame(8'h20, 32'h13572468, 40, -1, 0, rd, en);
        model_write(7'h20, 32'h13572468);
        checks++;
        if (wr_q.size() !== 0) begin
            errors++;
            $display("FAIL bad_addr_pulse: got %0d pulses required 0", wr_q.size());
        end
        wr_q.delete();
        io_update();
        do_frame(8'h80, 32'h0, 40, -1, 0, rd, en);
        checks++;
        if (rd !== model_read(7'h00)) begin
            errors++;
            $display("FAIL bad_addr_reg0: got %h required %h", rd, model_read(7'h00));
        end
        do_frame(8'hA0, 32'h0, 40, -1, 0, rd, en);
        checks++;
        if (rd !== model_read(7'h20)) begin
            errors++;
            $display("FAIL bad_addr_read: got %h required %h", rd, model_read(7'h20));
        end
        $display("write/read 0x20 out of range, read = %h", rd);
    endtask

    task automatic test_abort();
        logic [31:0] rd;
        logic [39:0] en;
        do_frame(8'h02, 32'hA5A50F0F, 40, -1, 0, rd, en);
        model_write(7'h02, 32'hA5A50F0F);
        wr_q.delete();
        for (int k = 0; k < 300; k++) begin
            do_frame(8'h02, $urandom, (k < 4) ? 20 : 3, -1, 0, rd, en);
            if (m_abort < 255) m_abort++;
            if (k == 0) begin
                checks++;
                if (opAbortCount !== 8'(m_abort)) begin
                    errors++;
                    $display("FAIL abort_first: got %0d required %0d", opAbortCount, m_abort);
                end
            end
        end
        checks++;
        if (wr_q.size() !== 0) begin
            errors++;
            $display("FAIL abort_pulse: got %0d pulses required 0", wr_q.size());
        end
        wr_q.delete();
        checks++;
        if (opAbortCount !== 8'(m_abort)) begin
            errors++;
            $display("FAIL abort_saturate: got %0d required %0d", opAbortCount, m_abort);
        end
        io_update();
        ipRdAddr = 4'd2;
        tick(2);
        checks++;
        if (opRdData !== m_active[2]) begin
            errors++;
            $display("FAIL abort_reg2: got %h required %h", opRdData, m_active[2]);
        end
        $display("300 aborted frames, abort count %0d, reg2 %h", opAbortCount, opRdData);
    endtask

    task automatic test_reset_rdata();
        logic [31:0] rd, d;
        logic [39:0] en;
        do_frame(8'h07, 32'h89ABCDEF, 40, -1, 0, rd, en);
        model_write(7'h07, 32'h89ABCDEF);
        io_update();
        wr_q.delete();
        ipRdAddr = 4'd7;
        do_frame(8'h87, 32'h0, 18, -1, 1, rd, en);
        checks++;
        if (opSDIO_En !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_en: got %b required 1", opSDIO_En);
        end
        ipReset = 1'b1;
        #1;
        checks++;
        if ({opSDIO_En, opSDIO, opRdData, opAbortCount} !== '0) begin
            errors++;
            $display("FAIL rst_async: en %b sdio %b rdata %h abort %0d required all 0",
                     opSDIO_En, opSDIO, opRdData, opAbortCount);
        end
        ipnCS = 1'b1; ipSClk = 1'b0; ipSDIO = 1'b0;
        tick(3);
        ipReset = 1'b0;
        model_reset();
        tick(3);
        d = $urandom;
        do_frame(8'h07, d, 40, -1, 0, rd, en);
        model_write(7'h07, d);
        checks++;
        if (wr_q.size() !== 1) begin
            errors++;
            $display("FAIL rst_next_wr: got %0d pulses required 1", wr_q.size());
        end
        wr_q.delete();
        io_update();
        do_frame(8'h87, 32'h0, 40, -1, 0, rd, en);
        checks++;
        if (rd !== model_read(7'h07)) begin
            errors++;
            $display("FAIL rst_next_read: got %h required %h", rd, model_read(7'h07));
        end
        $display("reset during read phase, next frame read %h", rd);
    endtask

    task automatic test_random();
        logic [31:0] rd, d;
        logic [39:0] en;
        logic [6:0]  a;
        int          op, u0;
        for (int t = 0; t < 30; t++) begin
            op = $urandom_range(0, 2);
            a  = 7'($urandom_range(0, 19));
            d  = $urandom;
            if (op == 0) begin
                do_frame({1'b0, a}, d, 40, -1, 0, rd, en);
                model_write(a, d);
                checks++;
                if (wr_q.size() !== ((a < NR) ? 1 : 0)) begin
                    errors++;
                    $display("FAIL rand_wr_count: addr %h got %0d pulses", a, wr_q.size());
                end else if (a < NR) begin
                    checks++;
                    if (wr_q[0] !== {a, d}) begin
                        errors++;
                        $display("FAIL rand_wr_word: got %h required %h", wr_q[0], {a, d});
                    end
                end
                wr_q.delete();
                $display("rand write addr %h data %h", a, d);
            end else if (op == 1) begin
                do_frame({1'b1, a}, 32'h0, 40, -1, 0, rd, en);
                checks++;
                if (rd !== model_read(a) || en !== {8'h00, 32'hFFFFFFFF}) begin
                    errors++;
                    $display("FAIL rand_read: addr %h got %h en %h required %h", a, rd, en, model_read(a));
                end
                $display("rand read addr %h data %h", a, rd);
            end else begin
                u0 = upd_cnt;
                io_update();
                checks++;
                if (upd_cnt !== u0 + 1) begin
                    errors++;
                    $display("FAIL rand_update: got %0d pulses required 1", upd_cnt - u0);
                end
                $display("rand io_update");
            end
        end
        for (int i = 0; i < NR; i++) begin
            ipRdAddr = 4'(i);
            tick(2);
            checks++;
            if (opRdData !== m_active[i]) begin
                errors++;
                $display("FAIL rand_rdport: addr %0d got %h required %h", i, opRdData, m_active[i]);
            end
        end
        $display("local read port swept over %0d registers", NR);
    endtask

    initial begin
        ipReset = 1'b1; ipSClk = 1'b0; ipnCS = 1'b1; ipSDIO = 1'b0;
        ipSyncIO = 1'b0; ipIO_Update = 1'b0; ipRdAddr = '0;
        model_reset();
        test_reset();
        test_write_update();
        test_read_shadow();
        test_syncio();
        test_bad_addr();
        test_abort();
        test_reset_rdata();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ad9915_spi_responder.md
Name: ad9915_spi_responder

Overview:
- Synthesisable serial-port responder emulating the AD9915 DDS register interface: the device end of the 3-wire SPI plus SyncIO/IO_Update that the synthesiser controller drives.
- Decodes write frames into a shadow register bank, promotes shadow to active on IO_Update, and serves read frames by driving SDIO back.
- Used in FPGA loopback and emulation builds in place of the physical DDS, and as the bus-side checker for the waveform subsystem.

Parameters:
- NUM_REGS, 16, number of implemented 32-bit registers (addresses 0..NUM_REGS-1).
- SYNC_STAGES, 2, synchroniser depth on every serial input (minimum 2).

Ports:
- ipClk  input  1  system clock; oversamples the serial bus.
- ipReset  input  1  asynchronous, active-high reset.
- ipSClk  input  1  serial clock from controller.
- ipnCS  input  1  active-low chip select.
- ipSDIO  input  1  serial data in; the controller drives it during the instruction and write phases.
- opSDIO  output  1  serial read data.
- opSDIO_En  output  1  high while the responder owns SDIO (read data phase only).
- ipSyncIO  input  1  serial-port reset; high aborts any frame.
- ipIO_Update  input  1  rising edge copies the shadow bank to the active bank.
- ipRdAddr  input  $clog2(NUM_REGS)  local read port address into the active bank.
- opRdData  output  32  active[ipRdAddr], registered, 1-cycle latency.
- opWrValid  output  1  1-cycle pulse per completed write word.
- opWrAddr  output  7  address of that word.
- opWrData  output  32  data of that word.
- opUpdatePulse  output  1  1-cycle pulse when the active bank is loaded.
- opAbortCount  output  8  saturating count of aborted frames.

Behaviour:
- Reset: all shadow and active registers 0; opSDIO=0, opSDIO_En=0, opWrValid=0, opWrAddr=0, opWrData=0, opUpdatePulse=0, opRdData=0, opAbortCount=0; FSM in IDLE.
- Input path: all serial inputs pass through SYNC_STAGES flip-flops, then a 1-stage edge detector. Bus timing requirement: SClk high and low phases each ≥4 ipClk.
- Frame format, MSB first:
  - Instruction byte: bit7 = R/nW (1 = read), bits6:0 = address.
  - Then exactly 32 data bits.
  - Write data is sampled on synchronised SClk rising edges.
  - Read data changes on SClk falling edges.
- FSM:
  - IDLE -> INSTR on nCS falling edge; bit counter cleared.
  - INSTR: shift 8 bits. After the 8th rising edge: R/nW=0 -> WDATA; R/nW=1 -> RDATA.
  - RDATA entry: load shift register with active[addr] (0 if addr ≥ NUM_REGS); assert opSDIO_En; drive opSDIO with bit31 from the next ipClk. Each following SClk falling edge shifts out the next bit. After the 32nd rising edge, deassert opSDIO_En -> DONE.
  - WDATA: shift 32 bits. On the 32nd rising edge:
    - If addr < NUM_REGS: write shadow[addr] and pulse opWrValid, opWrAddr, opWrData on the following cycle.
    - If addr ≥ NUM_REGS: discard silently, no pulse.
    - Then -> DONE.
  - DONE: extra SClk edges are ignored; nCS rising edge -> IDLE.
- Abort: nCS rising edge in INSTR, WDATA or RDATA returns to IDLE, drops opSDIO_En immediately, discards partial data and increments opAbortCount (saturates at 255).
- SyncIO: synchronised ipSyncIO high forces IDLE, drops opSDIO_En and discards partial data. It does not count as an abort. The FSM stays in IDLE while SyncIO is high; a new frame needs a fresh nCS falling edge.
- IO_Update:
  - On the synchronised rising edge, active <= shadow (all registers in one cycle) and opUpdatePulse is asserted in the same cycle the bank loads.
  - If a write completes in the same cycle as an IO_Update edge, the copy uses the new shadow value.
  - Reads always return the active bank, never the shadow bank.
- Reset mid-frame: every state and output returns to its reset value immediately (asynchronous).

Test Plan:
- Write 0x05 / 0x12345678, then IO_Update -> one opWrValid with opWrAddr=0x05, opWrData=0x12345678; after the update, opUpdatePulse=1 once and ipRdAddr=5 gives opRdData=0x12345678 one cycle later.
- Write 0x03 / 0xDEADBEEF with no IO_Update, then read 0x83 -> 32 bits on opSDIO equal 0x00000000; opSDIO_En is high for exactly the read data phase. Pulse IO_Update and read again -> 0xDEADBEEF.
- Raise nCS after 20 of 40 bits of a write to 0x02 -> no opWrValid, shadow[2] unchanged, opAbortCount=1. Repeat 300 times -> opAbortCount=255.
- Write to address 0x20 with NUM_REGS=16 -> no opWrValid. Read of 0xA0 -> shifts out 0x00000000.
- Pulse SyncIO mid-instruction, then send a clean frame writing 0x01 / 0x0000FFFF -> the frame is accepted, opWrData=0x0000FFFF, opAbortCount unchanged.
- Assert ipReset during the RDATA phase -> opSDIO_En=0 immediately, opRdData=0, FSM in IDLE; the next frame decodes normally.
